// File: rtl/sum_pkg.sv
// Shared types and helpers for the summer datapath and its downstream buffer.
package sum_pkg;

  localparam int unsigned SUM_DATA_W = 4;

  typedef logic [SUM_DATA_W-1:0] sum_word_t;

  // Width needed to count 0..depth inclusive
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sum_buffer_if.sv
// Stream bundle around sum_buffer: valid-only ingress, valid/ready egress.
interface sum_buffer_if
  import sum_pkg::*;
#(
  parameter int unsigned DATA_W = SUM_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/sum_buffer_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module sum_buffer_mem #(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sum_buffer.sv
// Elastic buffer behind the summer: never stalls upstream, drops and flags words when full.
// Optional drop counter enabled by defining SUM_BUFFER_DROP_CNT_EN.
module sum_buffer
  import sum_pkg::*;
#(
  parameter  int unsigned DATA_W = SUM_DATA_W,
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned CNT_W  = 8,
  localparam int unsigned LVL_W  = level_w(DEPTH),
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  sum_buffer_if.slave      bus,
  input  logic             ovf_clr,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              in_vld, push, pop, drop;
  logic [DATA_W-1:0] head;

  sum_buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // An unknown valid from upstream is never taken as a word
  assign in_vld = (bus.in_valid === 1'b1);
  assign empty  = (level_q == '0);
  assign full   = (level_q == LVL_W'(DEPTH));
  assign pop    = !empty && bus.out_ready;
  assign push   = in_vld && (!full || pop);
  assign drop   = in_vld && full && !pop;

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : head;
  assign level         = level_q;
  assign overflow      = overflow_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef SUM_BUFFER_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop count; a clear coinciding with a drop counts that drop
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && ovf_clr) begin
      drop_cnt_d = CNT_W'(1);
    end else if (drop) begin
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end else if (ovf_clr) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule
